// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the CPU memory-port arbiter.
// Owner and FSM encodings are fixed values so waveforms and checkers read the same numbers.
package mem_port_arbiter_pkg;

  localparam int WORD             = 32;
  localparam logic [31:0] START_ADRS = 32'h0000_0200;
  localparam int MEM_TIMEOUT      = 15;
  localparam int STARVE_LIMIT_DEF = 3;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/arb_prio_starve.sv
// Winner selection between fetch and data requesters while the port is idle.
// Data normally wins a contest; after STARVE_LIMIT contested data wins fetch is forced through.
module arb_prio_starve #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk_cpu,
  input  logic reset,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic if_win,
  output logic d_win
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign d_win      = arb_en & d_req & ~(if_req & starve_hit);
  assign if_win     = arb_en & if_req & ~d_win;

  // Counter saturates at the limit: a contested data win is impossible once it is reached.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_win) begin
      starve_cnt <= '0;
    end else if (d_win && if_req) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single CPU memory port between instruction fetch and load/store.
// Handshake: a requester holds req and its fields until the one-cycle gnt pulse; done pulses once per access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = WORD,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = MEM_TIMEOUT
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state;
  owner_e            owner;
  logic              lat_we;
  logic [3:0]        lat_be;
  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              idle;
  logic              if_win;
  logic              d_win;
  logic [DATA_W-1:0] gnt_addr;

  assign idle     = (state == ST_IDLE);
  assign gnt_addr = d_win ? d_addr : if_addr;

  arb_prio_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk_cpu(clk_cpu),
    .reset  (reset),
    .arb_en (idle),
    .if_req (if_req),
    .d_req  (d_req),
    .if_win (if_win),
    .d_win  (d_win)
  );

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      lat_we     <= 1'b0;
      lat_be     <= 4'h0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (if_win || d_win) begin
            owner     <= d_win ? OWN_D : OWN_IF;
            lat_we    <= d_win & d_we;
            lat_be    <= d_win ? d_be : 4'hF;
            lat_addr  <= gnt_addr;
            lat_wdata <= d_win ? d_wdata : '0;
            tmo_cnt   <= '0;
            // Misaligned accesses never reach memory; they fault straight away.
            if (is_misaligned(gnt_addr[1:0])) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= ST_RESP;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            resp_rdata <= lat_we ? '0 : mem_rdata;
            resp_err   <= 1'b0;
            state      <= ST_RESP;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            state      <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory-side and response outputs decode from state so reset clears them without waiting for a clock.
  assign mem_req   = (state == ST_BUSY);
  assign mem_we    = mem_req & lat_we;
  assign mem_be    = mem_req ? lat_be : 4'h0;
  assign mem_addr  = mem_req ? lat_addr : '0;
  assign mem_wdata = mem_req ? lat_wdata : '0;

  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign if_done   = (state == ST_RESP) && (owner == OWN_IF);
  assign d_done    = (state == ST_RESP) && (owner == OWN_D);
  assign if_rdata  = if_done ? resp_rdata : '0;
  assign d_rdata   = d_done ? resp_rdata : '0;
  assign if_err    = if_done & resp_err;
  assign d_err     = d_done & resp_err;

  assign busy      = ~idle;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then two random requesters against a memory responder,
// with a reference model predicting arbitration, response data and completion cycle for every access.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int STARVE = 3;
  localparam int TMO    = 15;
  localparam int EXP_W  = 66;   // {owner, err, rdata, done_cycle}
  localparam int MEM_W  = 77;   // {we, be, addr, wdata, delay}

  logic        clk_cpu;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_done, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_done, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;
  logic [1:0]  state_dbg;

  mem_port_arbiter #(
    .DATA_W(32), .STARVE_LIMIT(STARVE), .TIMEOUT(TMO)
  ) dut (
    .clk_cpu(clk_cpu), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  int cyc = 0;
  always @(posedge clk_cpu) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [MEM_W-1:0] mem_q[$];
  int force_delay_q[$];
  int starve_model = 0;
  int free_cyc = 0;
  bit rst_abort = 1'b0;
  logic [31:0] last_if_rdata = '0;

  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] sim_mem [logic [29:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[17:2] ^ 16'h5a5a, ~a[17:2]};
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return init_word(a);
  endfunction

  function automatic logic [31:0] sim_rd(input logic [31:0] a);
    if (sim_mem.exists(a[31:2])) return sim_mem[a[31:2]];
    return init_word(a);
  endfunction

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 19);
    if (r < 15) return r % 5;
    if (r < 17) return TMO - 1;
    return TMO + $urandom_range(0, 3);
  endfunction

  // ---------------- reference model: arbitration + expected response ----------------
  initial begin : grant_model
    logic        exp_d, grant_now, e_we, e_err;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd, e_rd;
    int          dly, e_cyc;
    forever begin
      @(negedge clk_cpu);
      if (reset) continue;
      grant_now = (cyc >= free_cyc) && (if_req || d_req);
      exp_d     = d_req && !(if_req && starve_model == STARVE);
      check("if_gnt", if_gnt, grant_now && !exp_d);
      check("d_gnt", d_gnt, grant_now && exp_d);
      if (grant_now) begin
        if (exp_d) begin
          e_we = d_we; e_be = d_be; e_addr = d_addr; e_wd = d_wdata;
          if (if_req) starve_model++;
        end else begin
          e_we = 1'b0; e_be = 4'hF; e_addr = if_addr; e_wd = '0;
          starve_model = 0;
        end
        dly = (force_delay_q.size() != 0) ? force_delay_q.pop_front() : pick_delay();
        if (e_addr[1:0] != 2'b00) begin
          e_err = 1'b1; e_rd = '0; e_cyc = cyc + 1;
        end else begin
          mem_q.push_back({e_we, e_be, e_addr, e_wd, 8'(dly)});
          if (dly >= TMO) begin
            e_err = 1'b1; e_rd = '0; e_cyc = cyc + TMO + 1;
          end else begin
            e_err = 1'b0; e_cyc = cyc + dly + 2;
            if (e_we) begin
              e_rd = '0;
              ref_mem[e_addr[31:2]] = merge_be(ref_rd(e_addr), e_wd, e_be);
            end else begin
              e_rd = ref_rd(e_addr);
            end
          end
        end
        free_cyc = e_cyc + 1;
        exp_q.push_back({exp_d, e_err, e_rd, 32'(e_cyc)});
      end
    end
  end

  // ---------------- memory responder ----------------
  initial begin : mem_resp
    logic [MEM_W-1:0] m;
    logic [31:0]      a;
    int               d, n;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk_cpu);
      if (!mem_req || reset) continue;
      if (mem_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_req_unexpected: got mem_req=1 addr %h expected no access (cycle %0d)",
                 mem_addr, cyc);
        for (int i = 0; i < 40; i++) begin
          @(negedge clk_cpu);
          if (!mem_req) break;
        end
        continue;
      end
      m = mem_q.pop_front();
      a = m[71:40];
      d = int'(m[7:0]);
      check("mem_we", mem_we, m[76]);
      check("mem_be", mem_be, m[75:72]);
      check("mem_addr", mem_addr, a);
      check("mem_wdata", mem_wdata, m[39:8]);
      if (d < TMO) begin
        for (int i = 0; i < d; i++) begin
          @(negedge clk_cpu);
          if (rst_abort) break;
        end
        if (!rst_abort) begin
          check("mem_req_held", mem_req, 1);
          check("mem_addr_stable", mem_addr, a);
          mem_ack = 1'b1;
          mem_rdata = m[76] ? $urandom : sim_rd(a);
          if (m[76]) sim_mem[a[31:2]] = merge_be(sim_rd(a), m[39:8], m[75:72]);
          @(posedge clk_cpu);
          #1;
          mem_ack = 1'b0;
          mem_rdata = '0;
        end
      end else begin
        n = 1;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk_cpu);
          if (!mem_req) break;
          n++;
        end
        if (!rst_abort) begin
          check("timeout_req_len", n, TMO);
          // Late acknowledge after the abort; it must be ignored.
          @(posedge clk_cpu);
          #1;
          mem_ack = 1'b1;
          mem_rdata = 32'hBAD0_0ACC;
          @(posedge clk_cpu);
          #1;
          mem_ack = 1'b0;
          mem_rdata = '0;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : done_mon
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk_cpu);
      if (if_done || d_done) begin
        if (if_done && d_done) check("done_both", {if_done, d_done}, 2'b01);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got if_done=%0d d_done=%0d expected none (cycle %0d)",
                   if_done, d_done, cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_owner", d_done, e[65]);
          check("rsp_err", if_done ? if_err : d_err, e[64]);
          check("rsp_rdata", if_done ? if_rdata : d_rdata, e[63:32]);
          check("done_cycle", cyc, e[31:0]);
          check("nonowner_rdata", if_done ? d_rdata : if_rdata, 0);
          if (if_done) last_if_rdata = if_rdata;
        end
      end else begin
        check("quiet_rsp", {if_err, d_err} | (if_rdata | d_rdata), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fetch_req(input logic [31:0] a);
    int n;
    @(posedge clk_cpu);
    #1;
    if_req = 1'b1;
    if_addr = a;
    for (n = 0; n < 300; n++) begin
      @(negedge clk_cpu);
      if (if_gnt) break;
    end
    if (n == 300) check("if_gnt_wait", 0, 1);
    @(posedge clk_cpu);
    #1;
    if_req = 1'b0;
    if_addr = $urandom;
  endtask

  task automatic data_req(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd);
    int n;
    @(posedge clk_cpu);
    #1;
    d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
    for (n = 0; n < 300; n++) begin
      @(negedge clk_cpu);
      if (d_gnt) break;
    end
    if (n == 300) check("d_gnt_wait", 0, 1);
    @(posedge clk_cpu);
    #1;
    d_req = 1'b0; d_we = $urandom; d_be = $urandom; d_addr = $urandom; d_wdata = $urandom;
  endtask

  task automatic wait_drain(input string name);
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk_cpu);
      if (exp_q.size() == 0) break;
    end
    if (n == 400) check(name, exp_q.size(), 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {24'h0, 2'b0, 6'($urandom_range(0, 63))} << 2;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    logic [7:0] order;
    int         ng, n;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    ref_mem[START_ADRS[31:2]] = 32'h2001_0005;
    sim_mem[START_ADRS[31:2]] = 32'h2001_0005;
    repeat (2) @(negedge clk_cpu);
    check("rst_busy", busy, 0);
    check("rst_mem_req", {mem_req, mem_we, mem_be}, 0);
    check("rst_mem_addr", mem_addr | mem_wdata, 0);
    check("rst_done", {if_done, d_done, if_gnt, d_gnt, if_err, d_err}, 0);
    @(posedge clk_cpu);
    #1;
    reset = 1'b0;

    // Fetch from the start address, memory acks on the second BUSY cycle.
    force_delay_q.push_back(1);
    fetch_req(START_ADRS);
    wait_drain("fetch_drain");
    check("fetch_word", last_if_rdata, 32'h2001_0005);

    // Partial store, then read it back.
    force_delay_q.push_back(0);
    data_req(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    force_delay_q.push_back(0);
    data_req(1'b0, 4'h0, 32'h100, 32'h0);
    wait_drain("store_drain");

    // Timeout with a late ack.
    force_delay_q.push_back(TMO + 5);
    data_req(1'b0, 4'h0, 32'h104, 32'h0);
    wait_drain("timeout_drain");
    repeat (4) @(negedge clk_cpu);
    check("timeout_busy", busy, 0);

    // Misaligned fetch.
    fetch_req(32'h102);
    wait_drain("misalign_drain");

    // Contention with zero-wait memory: D,D,D,IF,D,D,D,IF.
    for (int i = 0; i < 8; i++) force_delay_q.push_back(0);
    @(posedge clk_cpu);
    #1;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80; d_wdata = '0;
    ng = 0;
    order = '0;
    for (n = 0; n < 100 && ng < 8; n++) begin
      @(negedge clk_cpu);
      if (if_gnt || d_gnt) begin
        order[7-ng] = d_gnt;
        ng++;
      end
    end
    @(posedge clk_cpu);
    #1;
    if_req = 1'b0;
    d_req = 1'b0;
    check("contention_order", order, 8'b1110_1110);
    wait_drain("contention_drain");

    // Reset while BUSY.
    force_delay_q.push_back(TMO + 5);
    data_req(1'b0, 4'h0, 32'h108, 32'h0);
    for (n = 0; n < 5; n++) begin
      @(negedge clk_cpu);
      if (mem_req) break;
    end
    check("pre_rst_mem_req", mem_req, 1);
    #2;
    rst_abort = 1'b1;
    reset = 1'b1;
    #1;
    check("async_rst_mem_req", mem_req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", {if_done, d_done}, 0);
    repeat (3) @(negedge clk_cpu);
    exp_q.delete();
    force_delay_q.delete();
    starve_model = 0;
    free_cyc = 0;
    @(posedge clk_cpu);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk_cpu);
    rst_abort = 1'b0;
    force_delay_q.push_back(2);
    fetch_req(START_ADRS);
    wait_drain("post_rst_drain");
    check("post_rst_fetch", last_if_rdata, 32'h2001_0005);

    // Random traffic from both requesters.
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk_cpu);
          fetch_req(rand_addr());
        end
      end
      begin
        for (int j = 0; j < 120; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk_cpu);
          data_req(1'($urandom), 4'($urandom), rand_addr(), $urandom);
        end
      end
    join
    wait_drain("final_drain");
    repeat (4) @(negedge clk_cpu);
    check("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single 32-bit memory port between the instruction-fetch requester and the load/store requester.
- Sequences each access on the port: arbitration, address/data launch, wait for the memory acknowledge, response return, timeout and alignment faults.
- Sits between the CPU core (fetch addresses start at `START_ADRS) and the unified instruction/data memory.

Parameters:
- DATA_W, 32, data and address width; matches `WORD.
- STARVE_LIMIT, 3, consecutive contested data wins before fetch is forced to win.
- TIMEOUT, 15, maximum cycles waiting for mem_ack before aborting with an error.

Ports:
- clk_cpu  in  1  CPU clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted (1-cycle pulse).
- if_done  out  1  fetch complete (1-cycle pulse).
- if_rdata  out  32  instruction word; valid with if_done.
- if_err  out  1  fetch fault; valid with if_done.
- d_req  in  1  data request; held with other d_* inputs until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  byte enables for stores.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted (1-cycle pulse).
- d_done  out  1  data access complete (1-cycle pulse).
- d_rdata  out  32  load data; valid with d_done.
- d_err  out  1  data fault; valid with d_done.
- mem_req  out  1  memory request; held until mem_ack or timeout.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid with mem_ack.
- mem_ack  in  1  memory access complete.
- busy  out  1  state != IDLE.

Behaviour:
- Clocking/reset: single clock clk_cpu; reset is asynchronous, active-high.
- Reset values: state IDLE; all outputs 0; starve_cnt and tmo_cnt cleared.
- Reset mid-access drops mem_req immediately and emits no done pulse.
- FSM states: IDLE, BUSY, RESP.
- IDLE, arbitration (combinational gnt):
  - Only d_req high: data wins.
  - Only if_req high: fetch wins.
  - Both high: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- Starvation counter:
  - Contested data win: starve_cnt++.
  - Any fetch grant: starve_cnt = 0.
  - Uncontested data win: starve_cnt unchanged.
- At the grant edge: latch owner, address, we/be/wdata (fetch: we=0, be=4'hF).
- Alignment fault: if addr[1:0] != 0, go straight to RESP with err=1, rdata=0; mem_req never asserted.
- Otherwise go to BUSY.
- BUSY:
  - mem_req=1 with stable latched fields; tmo_cnt counts cycles without ack.
  - On mem_ack: capture mem_rdata (0 for stores), err=0, go to RESP.
  - If tmo_cnt reaches TIMEOUT without ack: drop mem_req, err=1, rdata=0, go to RESP.
- RESP: owner's done=1 for exactly one cycle with rdata/err; go to IDLE.
- Latency: grant cycle G; mem_req high from G+1; ack at cycle A gives done at A+1; next grant no earlier than A+2.
  - Zero-wait memory (ack at G+1): done at G+2.
- mem_ack outside BUSY is ignored, including a late ack after a timeout.
- Requesters may change fields the cycle after gnt; the arbiter uses latched copies only.
- Only one outstanding access at a time.
- Non-owner done/rdata stay 0.

Decomposition:
- Shared package/defines (extend defines.v): owner encoding (OWN_IF=0, OWN_D=1), FSM state encodings, MEM_TIMEOUT default.
- Reuse `WORD for data/address widths.
- One natural sub-module: arb_prio_starve, the IDLE-state winner selection plus starvation counter.
- Everything else stays in the top module.

Test Plan:
- Fetch only: if_req, if_addr=`START_ADRS; memory acks 2 cycles after mem_req with 32'h20010005 -> if_gnt at G, mem_addr=`START_ADRS, if_done at G+3 with if_rdata=32'h20010005, if_err=0.
- Contention: if_req and d_req held high continuously, zero-wait memory -> grant order D,D,D,IF,D,D,D,IF…; fetch never waits more than 3 data accesses.
- Store: d_we=1, d_be=4'b0011, d_addr=32'h100, d_wdata=32'hDEADBEEF -> mem_we=1, mem_be=4'b0011, mem_wdata=32'hDEADBEEF; d_done with d_rdata=0.
- Timeout: mem_ack never asserted -> mem_req high for exactly 15 cycles, then d_done with d_err=1; an ack 2 cycles later is ignored, busy=0.
- Misaligned: if_addr=32'h102 -> if_gnt, then if_done with if_err=1 one cycle later; mem_req stays 0 throughout.
- Reset in BUSY: assert reset asynchronously between edges -> mem_req, busy and done drop immediately; after release, a new fetch completes normally.
